// File: rtl/store_buffer_if.sv
// CPU MEM-stage and data-memory signal bundle for the store buffer.
// slave = the store buffer itself, master = the pipeline/memory environment.
interface store_buffer_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          cpu_wr;
    logic          cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          sb_empty;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_wr, cpu_rd, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, sb_empty, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_wr, cpu_rd, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, sb_empty, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores drained in the background, loads forwarded from
// the youngest match or read from memory (2+ stall cycles). Full buffer stalls stores.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, RD_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rd_buf_q, rd_buf_d;

    logic          full, push, pop, hit, load_miss;
    logic [DW-1:0] hit_data;

    // Scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == bus.cpu_addr) begin
                hit      = 1'b1;
                hit_data = data_q[head_q + PW'(i)];
            end
        end
    end

    // A simultaneous rd+wr is treated as a store only.
    assign full      = (count_q == CW'(DEPTH));
    assign push      = bus.cpu_wr && !full;
    assign pop       = (state_q == DRAIN) && bus.mem_ack;
    assign load_miss = bus.cpu_rd && !bus.cpu_wr && !hit;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    assign bus.cpu_stall = (bus.cpu_wr && full) || (load_miss && state_q != RD_DONE);
    assign bus.cpu_rdata = (state_q == RD_DONE) ? rd_buf_q : (hit ? hit_data : '0);
    assign bus.sb_empty  = (count_q == '0) && (state_q == IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_buf_d    = rd_buf_q;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.cpu_addr;
                    state_d    = RD_REQ;
                end else if (count_q != '0) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[head_q];
                    mem_wdata_d = data_q[head_q];
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_REQ: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    rd_buf_d  = bus.mem_rdata;
                    state_d   = RD_DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_buf_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_buf_q    <= rd_buf_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
        end
    end

    // Entry storage needs no reset: validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= bus.cpu_addr;
            data_q[tail_q] <= bus.cpu_wdata;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: expected memory transactions queued as stimulus is driven,
// popped as the memory side completes them; per-scenario inline cycle checks.
module tb_store_buffer;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xact_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(AW), .DW(DW)) sb ();
    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(sb));

    logic [DW-1:0] mem_model [128];
    assign sb.mem_rdata = mem_model[sb.mem_addr];

    int    vectors = 0;
    int    miscompares = 0;
    xact_t exp_wq[$];
    xact_t exp_rq[$];
    bit    ack_auto = 1'b0;
    int    ack_wait = 0;
    int    req_age = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (sb.mem_req) begin
            if (ack_auto) sb.mem_ack = (req_age >= ack_wait);
            req_age++;
        end else begin
            req_age = 0;
            if (ack_auto) sb.mem_ack = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        sb.cpu_wr = 1'b0; sb.cpu_rd = 1'b0; sb.cpu_addr = '0; sb.cpu_wdata = '0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_push);
        sb.cpu_wr = 1'b1; sb.cpu_rd = 1'b0; sb.cpu_addr = a; sb.cpu_wdata = d;
        if (expect_push) exp_wq.push_back(xact_t'{a, d});
    endtask

    task automatic do_reset();
        idle_inputs();
        ack_auto = 1'b0; sb.mem_ack = 1'b0;
        rst_n = 1'b0;
        exp_wq.delete(); exp_rq.delete();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_empty(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            ok = sb.sb_empty;
        end
    endtask

    // Memory-side scoreboard: every completing transaction must match the next expected one.
    task automatic monitor();
        xact_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb.mem_req && sb.mem_ack) begin
                vectors++;
                if (sb.mem_we) begin
                    if (exp_wq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_write got addr=%h data=%h, none expected", sb.mem_addr, sb.mem_wdata);
                    end else begin
                        e = exp_wq.pop_front();
                        if (sb.mem_addr !== e.a || sb.mem_wdata !== e.d) begin
                            miscompares++;
                            $display("FAIL write_order got %h:%h exp %h:%h", sb.mem_addr, sb.mem_wdata, e.a, e.d);
                        end
                    end
                end else begin
                    if (exp_rq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_read got addr=%h, none expected", sb.mem_addr);
                    end else begin
                        e = exp_rq.pop_front();
                        if (sb.mem_addr !== e.a) begin
                            miscompares++;
                            $display("FAIL read_addr got %h exp %h", sb.mem_addr, e.a);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        sb.mem_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        tick(); #2;
        vectors++; if (sb.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %b exp 0", sb.mem_req); end
        vectors++; if (sb.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got %b exp 0", sb.mem_we); end
        vectors++; if (sb.mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr got %h exp 0", sb.mem_addr); end
        vectors++; if (sb.mem_wdata !== '0) begin miscompares++; $display("FAIL rst_mem_wdata got %h exp 0", sb.mem_wdata); end
        vectors++; if (sb.cpu_rdata !== '0) begin miscompares++; $display("FAIL rst_cpu_rdata got %h exp 0", sb.cpu_rdata); end
        vectors++; if (sb.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_stall got %b exp 0", sb.cpu_stall); end
        vectors++; if (sb.sb_empty !== 1'b1) begin miscompares++; $display("FAIL rst_sb_empty got %b exp 1", sb.sb_empty); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_drain();
        do_reset();
        ack_auto = 1'b1; ack_wait = 0;
        tick(); store(7'h05, 32'hDEADBEEF, 1'b1); #2;
        vectors++; if (sb.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL drain_store_stall got %b exp 0", sb.cpu_stall); end
        tick(); idle_inputs(); #2;
        vectors++; if (sb.mem_req !== 1'b0) begin miscompares++; $display("FAIL drain_n1_req got %b exp 0", sb.mem_req); end
        vectors++; if (sb.sb_empty !== 1'b0) begin miscompares++; $display("FAIL drain_n1_empty got %b exp 0", sb.sb_empty); end
        tick(); #2;
        vectors++; if ({sb.mem_req, sb.mem_we} !== 2'b11) begin miscompares++; $display("FAIL drain_n2_req_we got %b exp 11", {sb.mem_req, sb.mem_we}); end
        vectors++; if (sb.mem_addr !== 7'h05) begin miscompares++; $display("FAIL drain_n2_addr got %h exp 05", sb.mem_addr); end
        vectors++; if (sb.mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL drain_n2_wdata got %h exp deadbeef", sb.mem_wdata); end
        tick(); #2;
        vectors++; if (sb.sb_empty !== 1'b1) begin miscompares++; $display("FAIL drain_n3_empty got %b exp 1", sb.sb_empty); end
        vectors++; if (exp_wq.size() !== 0) begin miscompares++; $display("FAIL drain_pending got %0d exp 0", exp_wq.size()); end
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        for (int a = 1; a <= 4; a++) begin
            tick(); store(AW'(a), 32'h100 + DW'(a), 1'b1); #2;
            vectors++; if (sb.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL full_accept%0d got stall %b exp 0", a, sb.cpu_stall); end
        end
        tick(); store(7'h05, 32'h105, 1'b0); #2;
        vectors++; if (sb.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL full_stall_a got %b exp 1", sb.cpu_stall); end
        ack_auto = 1'b1; ack_wait = 0;
        tick(); #2;
        vectors++; if (sb.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL full_stall_pop_edge got %b exp 1", sb.cpu_stall); end
        tick(); #2;
        vectors++; if (sb.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL full_release got %b exp 0", sb.cpu_stall); end
        exp_wq.push_back(xact_t'{7'h05, 32'h105});
        tick(); idle_inputs();
        wait_empty(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_drain_timeout got empty %b exp 1", ok); end
        vectors++; if (exp_wq.size() !== 0) begin miscompares++; $display("FAIL full_pending got %0d exp 0", exp_wq.size()); end
    endtask

    task automatic test_forward();
        bit ok;
        do_reset();
        tick(); store(7'h10, 32'h1, 1'b1);
        tick(); store(7'h12, 32'h3, 1'b1);
        tick(); store(7'h10, 32'h2, 1'b1);
        tick(); idle_inputs(); sb.cpu_rd = 1'b1; sb.cpu_addr = 7'h10; #2;
        vectors++; if (sb.cpu_rdata !== 32'h2) begin miscompares++; $display("FAIL fwd_youngest got %h exp 2", sb.cpu_rdata); end
        vectors++; if (sb.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL fwd_stall got %b exp 0", sb.cpu_stall); end
        sb.cpu_addr = 7'h12; #2;
        vectors++; if (sb.cpu_rdata !== 32'h3) begin miscompares++; $display("FAIL fwd_other got %h exp 3", sb.cpu_rdata); end
        tick(); idle_inputs();
        ack_auto = 1'b1; ack_wait = 0;
        wait_empty(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL fwd_drain_timeout got empty %b exp 1", ok); end
        vectors++; if (exp_wq.size() !== 0) begin miscompares++; $display("FAIL fwd_pending got %0d exp 0", exp_wq.size()); end
    endtask

    task automatic test_miss();
        do_reset();
        ack_auto = 1'b1; ack_wait = 1;
        tick(); sb.cpu_rd = 1'b1; sb.cpu_addr = 7'h20; exp_rq.push_back(xact_t'{7'h20, 32'hCAFE}); #2;
        vectors++; if ({sb.cpu_stall, sb.mem_req} !== 2'b10) begin miscompares++; $display("FAIL miss_n0 stall,req got %b exp 10", {sb.cpu_stall, sb.mem_req}); end
        tick(); #2;
        vectors++; if ({sb.cpu_stall, sb.mem_req, sb.mem_we} !== 3'b110) begin miscompares++; $display("FAIL miss_n1 stall,req,we got %b exp 110", {sb.cpu_stall, sb.mem_req, sb.mem_we}); end
        vectors++; if (sb.mem_addr !== 7'h20) begin miscompares++; $display("FAIL miss_n1_addr got %h exp 20", sb.mem_addr); end
        tick(); #2;
        vectors++; if (sb.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL miss_n2_stall got %b exp 1", sb.cpu_stall); end
        tick(); #2;
        vectors++; if (sb.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL miss_n3_stall got %b exp 0", sb.cpu_stall); end
        vectors++; if (sb.cpu_rdata !== 32'hCAFE) begin miscompares++; $display("FAIL miss_n3_rdata got %h exp cafe", sb.cpu_rdata); end
        tick(); idle_inputs(); #2;
        vectors++; if (sb.sb_empty !== 1'b1) begin miscompares++; $display("FAIL miss_done_empty got %b exp 1", sb.sb_empty); end
        vectors++; if (exp_rq.size() !== 0) begin miscompares++; $display("FAIL miss_pending got %0d exp 0", exp_rq.size()); end
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        tick(); store(7'h40, 32'hA, 1'b1);
        tick(); store(7'h41, 32'hB, 1'b1);
        tick(); idle_inputs(); sb.cpu_rd = 1'b1; sb.cpu_addr = 7'h30; exp_rq.push_back(xact_t'{7'h30, 32'h5555}); #2;
        vectors++; if ({sb.cpu_stall, sb.mem_req, sb.mem_we} !== 3'b111) begin miscompares++; $display("FAIL prio_c2 stall,req,we got %b exp 111", {sb.cpu_stall, sb.mem_req, sb.mem_we}); end
        vectors++; if (sb.mem_addr !== 7'h40) begin miscompares++; $display("FAIL prio_c2_addr got %h exp 40", sb.mem_addr); end
        tick(); sb.mem_ack = 1'b1; #2;
        vectors++; if (sb.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL prio_c3_stall got %b exp 1", sb.cpu_stall); end
        tick(); sb.mem_ack = 1'b0; #2;
        vectors++; if ({sb.cpu_stall, sb.mem_req} !== 2'b10) begin miscompares++; $display("FAIL prio_c4 stall,req got %b exp 10", {sb.cpu_stall, sb.mem_req}); end
        tick(); #2;
        vectors++; if ({sb.mem_req, sb.mem_we} !== 2'b10) begin miscompares++; $display("FAIL prio_c5 req,we got %b exp 10", {sb.mem_req, sb.mem_we}); end
        vectors++; if (sb.mem_addr !== 7'h30) begin miscompares++; $display("FAIL prio_c5_addr got %h exp 30", sb.mem_addr); end
        sb.mem_ack = 1'b1;
        tick(); sb.mem_ack = 1'b0; #2;
        vectors++; if (sb.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL prio_c6_stall got %b exp 0", sb.cpu_stall); end
        vectors++; if (sb.cpu_rdata !== 32'h5555) begin miscompares++; $display("FAIL prio_c6_rdata got %h exp 5555", sb.cpu_rdata); end
        idle_inputs();
        tick(); #2;
        vectors++; if (sb.mem_req !== 1'b0) begin miscompares++; $display("FAIL prio_c7_req got %b exp 0", sb.mem_req); end
        tick(); #2;
        vectors++; if ({sb.mem_req, sb.mem_we} !== 2'b11) begin miscompares++; $display("FAIL prio_c8 req,we got %b exp 11", {sb.mem_req, sb.mem_we}); end
        vectors++; if (sb.mem_addr !== 7'h41) begin miscompares++; $display("FAIL prio_c8_addr got %h exp 41", sb.mem_addr); end
        sb.mem_ack = 1'b1;
        tick(); sb.mem_ack = 1'b0;
        wait_empty(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL prio_drain_timeout got empty %b exp 1", ok); end
        vectors++; if (exp_wq.size() + exp_rq.size() !== 0) begin miscompares++; $display("FAIL prio_pending got %0d exp 0", exp_wq.size() + exp_rq.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ack_auto = 1'b1; ack_wait = 0;
        tick(); store(7'h60, 32'h6, 1'b1);
        tick(); idle_inputs();
        tick(); store(7'h61, 32'h7, 1'b1); #2;
        vectors++; if ({sb.mem_req, sb.cpu_stall} !== 2'b10) begin miscompares++; $display("FAIL b2b_c2 req,stall got %b exp 10", {sb.mem_req, sb.cpu_stall}); end
        tick(); idle_inputs(); #2;
        vectors++; if ({sb.sb_empty, sb.mem_req} !== 2'b00) begin miscompares++; $display("FAIL b2b_c3 empty,req got %b exp 00", {sb.sb_empty, sb.mem_req}); end
        tick(); #2;
        vectors++; if (sb.mem_addr !== 7'h61 || sb.mem_req !== 1'b1) begin miscompares++; $display("FAIL b2b_c4 req=%b addr=%h exp req=1 addr=61", sb.mem_req, sb.mem_addr); end
        tick(); #2;
        vectors++; if (sb.sb_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_c5_empty got %b exp 1", sb.sb_empty); end
        vectors++; if (exp_wq.size() !== 0) begin miscompares++; $display("FAIL b2b_pending got %0d exp 0", exp_wq.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(); store(7'h50, 32'h9, 1'b1);
        tick(); idle_inputs();
        tick(); #2;
        vectors++; if (sb.mem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_req_before got %b exp 1", sb.mem_req); end
        rst_n = 1'b0; #1;
        vectors++; if (sb.mem_req !== 1'b0) begin miscompares++; $display("FAIL rmid_async_req got %b exp 0", sb.mem_req); end
        vectors++; if (sb.sb_empty !== 1'b1) begin miscompares++; $display("FAIL rmid_async_empty got %b exp 1", sb.sb_empty); end
        exp_wq.delete();
        sb.mem_ack = 1'b1;
        tick(); tick();
        sb.mem_ack = 1'b0;
        rst_n = 1'b1;
        ack_auto = 1'b1; ack_wait = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); #2;
            vectors++; if ({sb.mem_req, sb.sb_empty} !== 2'b01) begin miscompares++; $display("FAIL rmid_after%0d req,empty got %b exp 01", i, {sb.mem_req, sb.sb_empty}); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = 32'h1000_0000 + DW'(i);
        mem_model[7'h20] = 32'hCAFE;
        mem_model[7'h30] = 32'h5555;
        idle_inputs();
        sb.mem_ack = 1'b0;
        fork monitor(); join_none
        test_reset();
        test_drain();
        test_full();
        test_forward();
        test_miss();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the CPU's MEM stage and a handshaked data memory. Stores are queued in a small FIFO and drained to memory in the background. Loads are served from the youngest matching buffered store, or else from memory with a stall. This decouples the pipeline's single-cycle MEM stage from multi-cycle memory latency.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2
- AW, 7, word-address width (byte address bits [8:2])
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- cpu_wr  in  1  store request from MEM stage
- cpu_rd  in  1  load request from MEM stage
- cpu_addr  in  AW  word address for load or store
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data, valid in the cycle cpu_rd is high and cpu_stall is low
- cpu_stall  out  1  combinational; holds IF/ID/EX/MEM while high
- sb_empty  out  1  no buffered stores and no memory transaction in flight
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read; registered
- mem_addr  out  AW  registered
- mem_wdata  out  DW  registered
- mem_ack  in  1  transaction completes at the clock edge where mem_req & mem_ack are both high
- mem_rdata  in  DW  read data, valid with mem_ack

## Operation
- **FIFO:** DEPTH entries of {addr, data}, with head/tail pointers wrapping modulo DEPTH. The count runs 0..DEPTH. There is no coalescing: duplicate addresses are queued separately.
- **Store:** a store is pushed at the edge when cpu_wr=1 and the buffer is not full.
- **Full:** when cpu_wr=1 and count==DEPTH, cpu_stall=1 and nothing is pushed. This holds even if a pop occurs on the same edge; the stall is based on the registered count.
- **Load hit:** on cpu_rd=1, all valid entries are searched. The youngest matching entry (closest to tail) drives cpu_rdata combinationally and cpu_stall=0. An entry currently being drained is still valid until its ack.
- **Load miss:** a miss stalls the CPU and performs a memory read via the FSM below.
- **cpu_rd and cpu_wr both high:** this is a protocol violation. The store takes effect and the load is ignored (cpu_stall follows the store rules only).
- **FSM states:**
  - IDLE:
    - A load miss (cpu_rd & !hit) latches cpu_addr and goes to RD_REQ; reads have priority over draining.
    - Else if count>0, the head entry is loaded into the mem_* registers and the state goes to DRAIN.
  - DRAIN: mem_req=1, mem_we=1. On ack, the head is popped and the state returns to IDLE.
  - RD_REQ: mem_req=1, mem_we=0. On ack, mem_rdata is captured into rd_buf and the state goes to RD_DONE.
  - RD_DONE: mem_req=0, cpu_rdata=rd_buf, cpu_stall=0, then back to IDLE.
- **cpu_stall:**
  - Asserted on (cpu_wr & full) or (cpu_rd & !hit & state!=RD_DONE).
  - A load miss arriving in DRAIN stalls until the drain acks, then follows IDLE→RD_REQ.
- **mem_req:** low in IDLE and RD_DONE. In DRAIN and RD_REQ, mem_req and the mem_* outputs are held stable until ack.
- **sb_empty:** equals (count==0 && state==IDLE).
- **Reset:**
  - Any time, including mid-transaction: state=IDLE, count=0, pointers=0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0 (with no hit), cpu_stall=0 (with cpu_rd/wr low), sb_empty=1.
  - In-flight and buffered stores are discarded, and mem_ack is ignored while rst_n is low.

## Timing
- **Store drain:**
  - cpu_wr in cycle N; count=1 in N+1 with state IDLE.
  - mem_req=1 from cycle N+2.
  - With a zero-wait ack in N+2, the pop happens at the end of N+2 and sb_empty=1 in N+3.
  - Sustained drain rate is one store per 2 cycles plus memory wait states.
- **Load hit:** zero stall cycles; data is combinational in the same cycle.
- **Load miss from IDLE:**
  - Stall in cycle N.
  - mem_req read in N+1; a zero-wait ack in N+1 gives RD_DONE in N+2, with data and stall low.
  - Minimum 2 stall cycles, plus one per memory wait cycle.
- **Load miss while in DRAIN:** waits for the drain ack, then +1 cycle to IDLE, then the above.
- **Simultaneous push and pop (count<DEPTH):** count is unchanged and pointers both advance.

## Test plan
- **Drain after reset:** reset, then store addr 0x05=0xDEADBEEF with mem_ack tied high → mem_req/mem_we=1, mem_addr=0x05, mem_wdata=0xDEADBEEF in cycle N+2; sb_empty=1 in N+3.
- **Full stall:** with mem_ack=0, store to addrs 1..5 in consecutive cycles → 4 accepted, cpu_stall=1 on the 5th. Raise ack → 5th accepted after the first pop, and memory sees addrs 1,2,3,4,5 in order.
- **Youngest-match forwarding:** with ack=0, store 0x10=0x1 then 0x10=0x2, then load 0x10 → cpu_rdata=0x2, cpu_stall=0, no mem read issued.
- **Load miss with 2-cycle memory latency:** memory holds 0x20=0xCAFE; load 0x20 → mem_req read in N+1, ack in N+2, cpu_rdata=0xCAFE with stall low in N+3 (3 stall cycles).
- **Read priority and ordering:** with 2 stores buffered and a drain in flight, issue a load miss to a different addr → drain completes, then the read is issued before the second store; the second store drains afterwards.
- **Reset mid-transaction:** assert rst_n=0 during DRAIN with ack=0 → mem_req=0 immediately (asynchronous); after release, sb_empty=1 and no write is issued.
